dm_arbiter: RTL

Two-port arbiter that shares the single data-memory port (9-bit byte address, 32-bit data, 3-bit dmOp) between the CPU load/store path (port 0) and a host/DMA requester (port 1). It is a registered state machine with round-robin fairness and a bounded burst length, so neither side can starve the other. It sits between the CPU/host and `dm` and drives `DMWr/addr/din/dmOp`. Port 0 uses `cpu_stall` to freeze the PC while it waits.

---
 rtl/dm_arb_pkg.sv | 28 ++
 rtl/dm_arb_burst_cnt.sv | 43 ++++
 rtl/dm_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared types and constants for the data-memory arbiter:
//   - arb_state_e   : arbiter FSM states (IDLE / OWN0 / OWN1)
//   - PORT_CPU/HOST : port index constants, also the encoding of the 'last' owner
//   - DM_OP_W       : width of the dmOp field passed through to dm
//   - DMOP_*        : dmOp encodings understood by dm (size / sign of the access)
// -----------------------------------------------------------------------------
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    localparam int DM_OP_W = 3;

    localparam logic [DM_OP_W-1:0] DMOP_WORD  = 3'd0;
    localparam logic [DM_OP_W-1:0] DMOP_HALF  = 3'd1;
    localparam logic [DM_OP_W-1:0] DMOP_HALFU = 3'd2;
    localparam logic [DM_OP_W-1:0] DMOP_BYTE  = 3'd3;
    localparam logic [DM_OP_W-1:0] DMOP_BYTEU = 3'd4;

endpackage

// File: rtl/dm_arb_burst_cnt.sv
// -----------------------------------------------------------------------------
// dm_arb_burst_cnt
// Saturating count of beats completed by the current owner of the dm port.
//   clk, rstn : clock, asynchronous active-low reset
//   clear     : owner is changing at this edge; restart the count
//   inc       : a beat completes this cycle
//   limit     : the beat in progress is the MAX_BURST-th (or later) one
// -----------------------------------------------------------------------------
module dm_arb_burst_cnt
    import dm_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic inc,
    output logic limit
);

    localparam int              CW    = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]   SAT   = CW'(MAX_BURST);
    localparam logic [CW-1:0]   FINAL = CW'(MAX_BURST - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its inputs, independent of block evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != SAT)) begin
            count <= count + 1'b1;
        end
    end

    // '>=' rather than '==': once a lone owner has saturated the count, a
    // newly arriving requester must still be able to take the port.
    assign limit = (count >= FINAL);

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Shares the single data-memory port between the CPU load/store path (port 0)
// and a host/DMA requester (port 1). Round-robin on ties, bounded bursts.
//
// Optional feature macro: DM_ARB_LOCK_EN
//   defined   : host_lock input exists; while port 1 owns dm and host_lock=1
//               the burst-limit handoff is suppressed.
//   undefined : no host_lock port; pure round-robin with burst limit.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   req0/1, we0/1        request (held until beat), write enable
//   addr0/1, wdata0/1    byte address, write data
//   op0/1                dmOp forwarded to dm
//   gnt0/1               registered grant; beat = reqN & gntN
//   rdata                dm_dout, valid in the beat cycle
//   cpu_stall            req0 & ~gnt0
//   host_lock            (DM_ARB_LOCK_EN only) port 1 burst lock
//   dm_we/addr/din/op    to dm
//   dm_dout              from dm (combinational read)
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW        = 9,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req0,
    input  logic               req1,
    input  logic               we0,
    input  logic               we1,
    input  logic [AW-1:0]      addr0,
    input  logic [AW-1:0]      addr1,
    input  logic [DW-1:0]      wdata0,
    input  logic [DW-1:0]      wdata1,
    input  logic [DM_OP_W-1:0] op0,
    input  logic [DM_OP_W-1:0] op1,
`ifdef DM_ARB_LOCK_EN
    input  logic               host_lock,
`endif
    output logic               gnt0,
    output logic               gnt1,
    output logic [DW-1:0]      rdata,
    output logic               cpu_stall,
    output logic               dm_we,
    output logic [AW-1:0]      dm_addr,
    output logic [DW-1:0]      dm_din,
    output logic [DM_OP_W-1:0] dm_op,
    input  logic [DW-1:0]      dm_dout
);

    arb_state_e state;
    logic       last;          // most recent owner, PORT_CPU / PORT_HOST
    logic       own_req;       // owner is requesting: a beat completes this cycle
    logic       oth_req;       // the non-owner is waiting
    logic       burst_limit;
    logic       lock_hold;
    logic       leave_own;
    logic       state_change;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        own_req = 1'b0;
        oth_req = 1'b0;
        case (state)
            OWN0: begin own_req = req0; oth_req = req1; end
            OWN1: begin own_req = req1; oth_req = req0; end
            default: ;
        endcase
    end

`ifdef DM_ARB_LOCK_EN
    assign lock_hold = (state == OWN1) & host_lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Owner gives up the port when it stops requesting, or when the other
    // side is waiting and this beat exhausts the burst allowance.
    assign leave_own    = (state != IDLE) &
                          (~own_req | (oth_req & burst_limit & ~lock_hold));
    assign state_change = leave_own | ((state == IDLE) & (req0 | req1));

    dm_arb_burst_cnt #(.MAX_BURST(MAX_BURST)) u_burst_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clear (state_change),
        .inc   (own_req),
        .limit (burst_limit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            last  <= PORT_HOST;   // port 0 wins the first tie after reset
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && req1)
                        state <= (last == PORT_HOST) ? OWN0 : OWN1;
                    else if (req0)
                        state <= OWN0;
                    else if (req1)
                        state <= OWN1;
                end
                OWN0:    if (leave_own) state <= req1 ? OWN1 : IDLE;
                OWN1:    if (leave_own) state <= req0 ? OWN0 : IDLE;
                default: state <= IDLE;
            endcase

            if (state == OWN0)
                last <= PORT_CPU;
            else if (state == OWN1)
                last <= PORT_HOST;
        end
    end

    assign gnt0      = (state == OWN0);
    assign gnt1      = (state == OWN1);
    assign cpu_stall = req0 & ~gnt0;
    assign rdata     = dm_dout;

    // dm write strobe follows the registered state, so the asynchronous reset
    // of 'state' drops an in-flight write without waiting for a clock edge.
    always_comb begin
        dm_we   = 1'b0;
        dm_addr = '0;
        dm_din  = '0;
        dm_op   = '0;
        case (state)
            OWN0: begin
                dm_we   = we0 & req0;
                dm_addr = addr0;
                dm_din  = wdata0;
                dm_op   = op0;
            end
            OWN1: begin
                dm_we   = we1 & req1;
                dm_addr = addr1;
                dm_din  = wdata1;
                dm_op   = op1;
            end
            default: ;
        endcase
    end

endmodule
